rv_decode_stage: RTL and testbench

Registered instruction-decode pipeline stage for the RV32/RV64 pipeline. It accepts fetched instructions over a valid/ready handshake and decodes the immediate, store byte-enable mask, register write-enable and register indices. It holds the results in a two-entry skid buffer so that full-throughput backpressure works without a combinational ready path. It sits between the fetch stage and the execute stage, and supports flush on branch mispredict or trap.

---
 rtl/rv_decode_pkg.sv | 46 ++++
 rtl/rv_instr_decoder.sv | 107 ++++++++++
 rtl/rv_decode_stage.sv | 100 ++++++++++
 tb/tb_rv_decode_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// Shared opcode/funct3 constants and decoded-instruction record types for the
// decode stage. One record typedef exists per supported XLEN.
package rv_decode_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  we;
    logic        we_reg;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        illegal;
  } dec32_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [7:0]  we;
    logic        we_reg;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        illegal;
  } dec64_t;

endpackage

// File: rtl/rv_instr_decoder.sv
// Combinational RV32/RV64 instruction decoder: instruction word and pc in,
// decoded record out. dec_t must be the package record matching XLEN.
module rv_instr_decoder
  import rv_decode_pkg::*;
#(
  parameter int  XLEN          = 32,
  parameter int  STRB_W        = XLEN / 8,
  parameter bit  CHECK_ILLEGAL = 1'b1,
  parameter type dec_t         = dec32_t
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output dec_t            dec_o
);

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic signed [31:0] imm32;
  logic [STRB_W-1:0] we;
  logic              we_reg;
  logic              bad;

  // All immediates are formed as signed 32-bit values, then widened by sign.
  function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  always_comb begin
    opc    = instr_i[6:0];
    f3     = instr_i[14:12];
    imm32  = '0;
    we     = '0;
    we_reg = 1'b0;
    bad    = 1'b0;
    case (opc)
      OPC_LOAD, OPC_OPIMM: begin
        imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
        we_reg = 1'b1;
      end
      OPC_AUIPC, OPC_LUI: begin
        imm32  = {instr_i[31:12], 12'b0};
        we_reg = 1'b1;
      end
      OPC_STORE: begin
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        case (f3)
          F3_SB:   we = STRB_W'(8'h01);
          F3_SH:   we = STRB_W'(8'h03);
          F3_SW:   we = STRB_W'(8'h0F);
          F3_SD: begin
            if (XLEN == 64) we = STRB_W'(8'hFF);
            else            bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_OP: we_reg = 1'b1;
      OPC_BRANCH: begin
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      end
      OPC_JALR: begin
        imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
        we_reg = 1'b1;
        if (f3 != 3'b000) bad = 1'b1;
      end
      OPC_JAL: begin
        imm32  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};
        we_reg = 1'b1;
      end
      OPC_OPIMM32: begin
        if (XLEN == 64) begin
          imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
          we_reg = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP32: begin
        if (XLEN == 64) we_reg = 1'b1;
        else            bad    = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    // Illegal encodings degrade to a NOP; the flag itself is optional.
    if (bad) begin
      imm32  = '0;
      we     = '0;
      we_reg = 1'b0;
    end
    if (instr_i[11:7] == 5'd0) we_reg = 1'b0;

    dec_o         = '0;
    dec_o.pc      = pc_i;
    dec_o.imm     = sext(imm32);
    dec_o.we      = we;
    dec_o.we_reg  = we_reg;
    dec_o.rd      = instr_i[11:7];
    dec_o.rs1     = instr_i[19:15];
    dec_o.rs2     = instr_i[24:20];
    dec_o.funct3  = f3;
    dec_o.illegal = bad & CHECK_ILLEGAL;
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage with a two-entry skid buffer: decode at the input,
// main entry drives the outputs, skid entry absorbs one beat of backpressure.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int  XLEN          = 32,
  parameter int  STRB_W        = XLEN / 8,
  parameter bit  CHECK_ILLEGAL = 1'b1,
  parameter type dec_t         = dec32_t
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [STRB_W-1:0] out_we,
  output logic              out_we_reg,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [2:0]        out_funct3,
  output logic              out_illegal
);

  dec_t in_dec;
  dec_t main_q, main_d, skid_q, skid_d;
  logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic accept, retire;

  rv_instr_decoder #(
    .XLEN          (XLEN),
    .STRB_W        (STRB_W),
    .CHECK_ILLEGAL (CHECK_ILLEGAL),
    .dec_t         (dec_t)
  ) u_dec (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (in_dec)
  );

  // Ready depends only on the skid flag, never on out_ready.
  assign in_ready = !skid_vld_q;
  assign accept   = in_valid & !skid_vld_q;
  assign retire   = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || retire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_dec;
      end
    end else if (accept) begin
      skid_d     = in_dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid   = main_vld_q;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_we      = main_q.we;
  assign out_we_reg  = main_q.we_reg;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct3  = main_q.funct3;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: an XLEN=32 and an XLEN=64 instance run in
// lockstep from the same instruction stream.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] pc64;

  logic        rdy32, vld32, wr32, il32;
  logic [31:0] pc32, imm32;
  logic [3:0]  we32;
  logic [4:0]  rd32, rs132, rs232;
  logic [2:0]  f332;

  logic        rdy64, vld64, wr64, il64;
  logic [63:0] pco64, imm64;
  logic [7:0]  we64;
  logic [4:0]  rd64, rs164, rs264;
  logic [2:0]  f364;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(pc64[31:0]),
    .out_valid(vld32), .out_ready(out_ready), .out_pc(pc32), .out_imm(imm32),
    .out_we(we32), .out_we_reg(wr32), .out_rd(rd32), .out_rs1(rs132),
    .out_rs2(rs232), .out_funct3(f332), .out_illegal(il32)
  );

  rv_decode_stage #(.XLEN(64), .dec_t(rv_decode_pkg::dec64_t)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(pc64),
    .out_valid(vld64), .out_ready(out_ready), .out_pc(pco64), .out_imm(imm64),
    .out_we(we64), .out_we_reg(wr64), .out_rd(rd64), .out_rs1(rs164),
    .out_rs2(rs264), .out_funct3(f364), .out_illegal(il64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm32, imm64;
    logic [7:0]  we32, we64;
    logic        wr32, wr64, il32, il64;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input int k);
    return 32'h0000_0093 | (32'(k) << 20);
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    in_valid = v;
    in_instr = ins;
    pc64     = pc;
  endtask

  task automatic chk_empty_zero(input string tag);
    chk({tag, "_vld32"}, vld32, 0);
    chk({tag, "_rdy32"}, rdy32, 1);
    chk({tag, "_pc32"},  pc32,  0);
    chk({tag, "_imm32"}, imm32, 0);
    chk({tag, "_we32"},  we32,  0);
    chk({tag, "_wr32"},  wr32,  0);
    chk({tag, "_rd32"},  rd32,  0);
    chk({tag, "_rs1"},   rs132, 0);
    chk({tag, "_rs2"},   rs232, 0);
    chk({tag, "_f3"},    f332,  0);
    chk({tag, "_il32"},  il32,  0);
    chk({tag, "_vld64"}, vld64, 0);
    chk({tag, "_rdy64"}, rdy64, 1);
    chk({tag, "_imm64"}, imm64, 0);
    chk({tag, "_pc64"},  pco64, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 8'h00, 1, 1, 0, 0, 5'd1,  5'd0,  5'd31, 3'd0};
    vt[1]  = '{32'h0020A423, 64'h8,        64'h8,                 8'h0F, 8'h0F, 0, 0, 0, 0, 5'd8,  5'd1,  5'd2,  3'd2};
    vt[2]  = '{32'h0080006F, 64'h8,        64'h8,                 8'h00, 8'h00, 0, 0, 0, 0, 5'd0,  5'd0,  5'd8,  3'd0};
    vt[3]  = '{32'hFFDFF0EF, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 8'h00, 8'h00, 1, 1, 0, 0, 5'd1,  5'd31, 5'd29, 3'd7};
    vt[4]  = '{32'h00000000, 64'h0,        64'h0,                 8'h00, 8'h00, 0, 0, 1, 1, 5'd0,  5'd0,  5'd0,  3'd0};
    vt[5]  = '{32'h0020B423, 64'h0,        64'h8,                 8'h00, 8'hFF, 0, 0, 1, 0, 5'd8,  5'd1,  5'd2,  3'd3};
    vt[6]  = '{32'h123452B7, 64'h12345000, 64'h12345000,          8'h00, 8'h00, 1, 1, 0, 0, 5'd5,  5'd8,  5'd3,  3'd5};
    vt[7]  = '{32'hFE208CE3, 64'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 8'h00, 8'h00, 0, 0, 0, 0, 5'd25, 5'd1,  5'd2,  3'd0};
    vt[8]  = '{32'h000090E7, 64'h0,        64'h0,                 8'h00, 8'h00, 0, 0, 1, 1, 5'd1,  5'd1,  5'd0,  3'd1};
    vt[9]  = '{32'hFE310FA3, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 8'h01, 8'h01, 0, 0, 0, 0, 5'd31, 5'd2,  5'd3,  3'd0};
    vt[10] = '{32'h002081B3, 64'h0,        64'h0,                 8'h00, 8'h00, 1, 1, 0, 0, 5'd3,  5'd1,  5'd2,  3'd0};
    vt[11] = '{32'h00001017, 64'h1000,     64'h1000,              8'h00, 8'h00, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  3'd1};
    vt[12] = '{32'h0010809B, 64'h0,        64'h1,                 8'h00, 8'h00, 0, 1, 1, 0, 5'd1,  5'd1,  5'd1,  3'd0};
    vt[13] = '{32'h800002B7, 64'h80000000, 64'hFFFFFFFF_80000000, 8'h00, 8'h00, 1, 1, 0, 0, 5'd5,  5'd0,  5'd0,  3'd0};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    tick();
    chk_empty_zero("reset");
    rst_n = 1'b1;

    // Single-instruction decode vectors with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      logic [63:0] pc;
      pc = 64'h0000_0001_0000_1000 + 64'(4 * i);
      drive(1'b1, vt[i].instr, pc);
      tick();
      drive(1'b0, 32'h0, 64'h0);
      chk($sformatf("v%0d_vld32", i), vld32, 1);
      chk($sformatf("v%0d_pc32", i),  pc32,  pc[31:0]);
      chk($sformatf("v%0d_imm32", i), imm32, vt[i].imm32);
      chk($sformatf("v%0d_we32", i),  we32,  vt[i].we32);
      chk($sformatf("v%0d_wr32", i),  wr32,  vt[i].wr32);
      chk($sformatf("v%0d_il32", i),  il32,  vt[i].il32);
      chk($sformatf("v%0d_rd", i),    rd32,  vt[i].rd);
      chk($sformatf("v%0d_rs1", i),   rs132, vt[i].rs1);
      chk($sformatf("v%0d_rs2", i),   rs232, vt[i].rs2);
      chk($sformatf("v%0d_f3", i),    f332,  vt[i].f3);
      chk($sformatf("v%0d_vld64", i), vld64, 1);
      chk($sformatf("v%0d_pc64", i),  pco64, pc);
      chk($sformatf("v%0d_imm64", i), imm64, vt[i].imm64);
      chk($sformatf("v%0d_we64", i),  we64,  vt[i].we64);
      chk($sformatf("v%0d_wr64", i),  wr64,  vt[i].wr64);
      chk($sformatf("v%0d_il64", i),  il64,  vt[i].il64);
      tick();
      chk($sformatf("v%0d_drain", i), vld32, 0);
    end

    // Three back-to-back with out_ready low for three edges.
    out_ready = 1'b0;
    drive(1'b1, addi(1), 64'd100);
    tick();
    chk("bp1_rdy", rdy32, 1);
    chk("bp1_vld", vld32, 1);
    chk("bp1_pc",  pc32,  100);
    drive(1'b1, addi(2), 64'd104);
    tick();
    chk("bp2_rdy",   rdy32, 0);
    chk("bp2_rdy64", rdy64, 0);
    chk("bp2_pc",    pc32,  100);
    drive(1'b1, addi(3), 64'd108);
    tick();
    chk("bp3_rdy", rdy32, 0);
    chk("bp3_pc",  pc32,  100);
    chk("bp3_imm", imm32, 1);
    out_ready = 1'b1;
    tick();
    chk("bp4_pc",  pc32,  104);
    chk("bp4_imm", imm32, 2);
    chk("bp4_rdy", rdy32, 1);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    chk("bp5_pc",  pc32,  108);
    chk("bp5_imm", imm32, 3);
    chk("bp5_vld", vld32, 1);
    tick();
    chk("bp6_vld", vld32, 0);

    // Full-rate streaming.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, addi(10 + k), 64'(300 + 4 * k));
      tick();
      chk($sformatf("st%0d_vld", k), vld32, 1);
      chk($sformatf("st%0d_imm", k), imm32, 32'(10 + k));
      chk($sformatf("st%0d_rdy", k), rdy32, 1);
    end
    drive(1'b0, 32'h0, 64'h0);
    tick();
    chk("st_end_vld", vld32, 0);

    // Flush with both entries full and an input offered on the same cycle.
    out_ready = 1'b0;
    drive(1'b1, addi(20), 64'd400);
    tick();
    drive(1'b1, addi(21), 64'd404);
    tick();
    chk("fl_full_rdy", rdy32, 0);
    flush = 1'b1;
    drive(1'b1, addi(22), 64'd408);
    tick();
    chk("fl_vld32", vld32, 0);
    chk("fl_rdy32", rdy32, 1);
    chk("fl_vld64", vld64, 0);
    chk("fl_rdy64", rdy64, 1);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 64'h0);
    tick();
    chk("fl_after_vld", vld32, 0);
    drive(1'b1, addi(23), 64'd412);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    chk("fl_new_vld", vld32, 1);
    chk("fl_new_imm", imm32, 23);
    chk("fl_new_pc",  pc32,  412);
    tick();

    // Reset while both entries are occupied.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFDFF0EF, 64'd500);
    tick();
    drive(1'b1, 32'h0020A423, 64'd504);
    tick();
    chk("rf_full_rdy", rdy32, 0);
    drive(1'b0, 32'h0, 64'h0);
    rst_n = 1'b0;
    tick();
    chk_empty_zero("rfull");
    rst_n = 1'b1;
    tick();
    chk("rf_post_vld", vld32, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
